// File: rtl/pipe_pkg.sv
// Shared constants and per-stage control structs for the pipeline stage registers.
// Stages cast their control structs to and from flat vectors of width <STAGE>_CTRL_W.
package pipe_pkg;

    localparam int unsigned PIPE_NOP_W = 256;
    localparam logic [PIPE_NOP_W-1:0] PIPE_CTRL_NOP = '0;

    typedef struct packed {
        logic       halt;
        logic       pred_taken;
    } if_id_ctrl_t;

    typedef struct packed {
        logic       reg_wrt;
        logic       mem_wrt;
        logic       mem_rd;
        logic       halt;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       reg_wrt;
        logic       mem_wrt;
        logic       mem_rd;
        logic       halt;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       reg_wrt;
        logic       halt;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } mem_wb_ctrl_t;

    localparam int unsigned IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
    localparam int unsigned ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    // instr + pc2 / rs1, rs2, imm, pc2 / alu result, store data, pc2 / mem data, alu result, pc2
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_DATA_W  = 128;
    localparam int unsigned EX_MEM_DATA_W = 96;
    localparam int unsigned MEM_WB_DATA_W = 96;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid + control + data flops with load enable and bubble clear.
// A bubble drops valid and forces the control to the NOP encoding; data holds.
module pipe_entry #(
    parameter int unsigned        CTRL_W   = 32,
    parameter int unsigned        DATA_W   = 64,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            data_q  <= '0;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline stage register with flush, NOP bubbles and a stall counter.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W   = 32,
    parameter int unsigned        DATA_W   = 64,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP),
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_bubble;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_bubble;

    // While the skid is full in_ready is low, so a drain refills main from skid only.
    assign in_ready     = !skid_valid;
    assign skid_load    = !flush && accept && out_valid && !out_ready;
    assign skid_bubble  = flush || (drain && skid_valid);
    assign main_load    = !flush && ((skid_valid && drain) ||
                                     (!skid_valid && accept && (!out_valid || out_ready)));
    assign main_bubble  = flush || (drain && !main_load);
    assign main_ctrl_in = skid_valid ? skid_ctrl : in_ctrl;
    assign main_data_in = skid_valid ? skid_data : in_data;

    pipe_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .bubble_i (skid_bubble),
        .ctrl_i   (in_ctrl),
        .data_i   (in_data),
        .valid_o  (skid_valid),
        .ctrl_o   (skid_ctrl),
        .data_o   (skid_data)
    );
`else
    assign in_ready     = !out_valid || out_ready;
    assign main_load    = accept && !flush;
    assign main_bubble  = flush || (drain && !accept);
    assign main_ctrl_in = in_ctrl;
    assign main_data_in = in_data;
`endif

    pipe_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load_i   (main_load),
        .bubble_i (main_bubble),
        .ctrl_i   (main_ctrl_in),
        .data_i   (main_data_in),
        .valid_o  (out_valid),
        .ctrl_o   (out_ctrl),
        .data_o   (out_data)
    );

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush = 1'b0;
    logic              clr_cnt = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP ('0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    // Reference model: an ordered queue of held transfers (capacity 1 or 2)
    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] m_last = '0;
    int                m_cnt  = 0;

    function automatic bit m_ready();
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                m_last = '0;
                m_cnt  = 0;
            end else begin
                bit acc, drn, stl;
                ent_t e;
                acc = in_valid && m_ready();
                drn = (mq.size() > 0) && out_ready;
                stl = (mq.size() > 0) && !out_ready;
                if (clr_cnt) m_cnt = 0;
                else if (stl && m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (drn) void'(mq.pop_front());
                    if (acc) begin
                        e.c = in_ctrl;
                        e.d = in_data;
                        mq.push_back(e);
                    end
                end
                if (mq.size() > 0) m_last = mq[0].d;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("mdl_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("mdl_in_ready",  64'(in_ready),  64'(m_ready()));
            chk("mdl_out_ctrl",  64'(out_ctrl),  (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
            chk("mdl_out_data",  64'(out_data),  64'(m_last));
            chk("mdl_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
    end

    task automatic drive(input bit v, input int d, input bit ordy, input bit fl, input bit clr);
        in_valid  = v;
        in_data   = DATA_W'(d);
        in_ctrl   = 32'hC000_0000 | CTRL_W'(d);
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        rst = 1'b1;

        // Streaming 1..8, one per cycle
        for (int d = 1; d <= 8; d++) begin
            drive(1, d, 1, 0, 0);
            step();
            chk("stream_data",  64'(out_data),  64'(d));
            chk("stream_valid", 64'(out_valid), 64'd1);
        end

        // Bubble between 5 and 6
        drive(1, 5, 1, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        chk("bubble_valid", 64'(out_valid), 64'd0);
        chk("bubble_ctrl",  64'(out_ctrl),  64'd0);
        chk("bubble_data",  64'(out_data),  64'd5);
        drive(1, 6, 1, 0, 0); step();
        chk("after_bubble", 64'(out_data), 64'd6);

        // Stall with 3 held, 4 offered
        drive(1, 3, 1, 0, 0); step();
        chk("stall_pre_cnt", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 4, 0, 0, 0);
            #1;
            chk("stall_in_ready", 64'(in_ready), (SKID && i == 0) ? 64'd1 : 64'd0);
            step();
            chk("stall_hold", 64'(out_data), 64'd3);
        end
        chk("stall_cnt4", 64'(stall_cnt), 64'd4);
        drive(!SKID, 4, 1, 0, 0); step();
        chk("stall_deliver4", 64'(out_data), 64'd4);
        chk("stall_valid4",   64'(out_valid), 64'd1);
        drive(0, 0, 1, 0, 0); step();
        chk("stall_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream with out_valid=1, stall_cnt=5
        drive(1, 9, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_cnt",   64'(stall_cnt), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ctrl",  64'(out_ctrl),  64'd0);
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_cnt",   64'(stall_cnt), 64'd0);
        chk("arst_ready", 64'(in_ready),  64'd1);
        step();
        rst = 1'b1;

        // Flush with main=7, skid=8 (skid build), concurrent offer of 10
        drive(1, 7, 1, 0, 0); step();
        drive(1, 8, 0, 0, 0); step();
        drive(1, 10, 1, 1, 0); step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl",  64'(out_ctrl),  64'd0);
        chk("flush_data",  64'(out_data),  64'd7);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0); step();
            chk("flush_gone", 64'(out_valid), 64'd0);
        end

        // Counter saturation and clear priority
        drive(1, 11, 1, 0, 0); step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0); step();
        end
        chk("cnt_sat", 64'(stall_cnt), 64'd15);
        drive(0, 0, 0, 0, 1); step();
        chk("cnt_clr", 64'(stall_cnt), 64'd0);
        drive(0, 0, 0, 0, 0); step();
        chk("cnt_after_clr", 64'(stall_cnt), 64'd1);
        drive(0, 0, 1, 0, 0); step();
        chk("final_drain", 64'(out_data), 64'd11);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
